// File: rtl/vedic_mult_iter.sv
// Iterative WIDTH x WIDTH multiplier: four passes through one shared H x H Vedic core,
// valid/ready on both sides. Define VEDIC_SIGNED_EN for two's-complement operands and product.
module vedic_mult_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   c,
  output logic                 busy
);

  localparam int H   = WIDTH / 2;
  localparam int PW  = 2 * WIDTH;
  localparam int LOG = $clog2(H);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [PW-1:0]    acc_q, acc_d, c_q, c_d;
  logic [H-1:0]     core_x, core_y;
  logic [WIDTH-1:0] pp;
  logic [PW-1:0]    pp_shift, acc_sum;

  // Shared core operands: step bit 0 picks the ra half, step bit 1 picks the rb half.
  always_comb begin
    core_x = step_q[0] ? ra_q[WIDTH-1:H] : ra_q[H-1:0];
    core_y = step_q[1] ? rb_q[WIDTH-1:H] : rb_q[H-1:0];
  end

  // Vedic core flattened into levels: level lv holds every (2<<lv)-bit digit-pair product,
  // built from the four half-size products of the level below.
  for (genvar lv = 0; lv < LOG; lv++) begin : g_lvl
    localparam int N = 2 << lv;
    localparam int D = H / N;
    logic [2*N-1:0] pr [D][D];
    for (genvar i = 0; i < D; i++) begin : g_i
      for (genvar j = 0; j < D; j++) begin : g_j
        if (lv == 0) begin : g_cell
          logic [1:0] x2, y2, t, u;
          assign x2 = core_x[2*i +: 2];
          assign y2 = core_y[2*j +: 2];
          assign t  = {1'b0, x2[1] & y2[0]} + {1'b0, x2[0] & y2[1]};
          assign u  = {1'b0, x2[1] & y2[1]} + {1'b0, t[1]};
          assign pr[i][j] = {u, t[0], x2[0] & y2[0]};
        end else begin : g_comb
          logic [N-1:0] ll, lh, hl, hh;
          logic [N:0]   mid;
          assign ll  = g_lvl[lv-1].pr[2*i][2*j];
          assign lh  = g_lvl[lv-1].pr[2*i+1][2*j];
          assign hl  = g_lvl[lv-1].pr[2*i][2*j+1];
          assign hh  = g_lvl[lv-1].pr[2*i+1][2*j+1];
          assign mid = {1'b0, lh} + {1'b0, hl};
          assign pr[i][j] = {hh, ll} + ((2*N)'(mid) << (N/2));
        end
      end
    end
  end

  assign pp = g_lvl[LOG-1].pr[0][0];

  always_comb begin
    case (step_q)
      2'd0:    pp_shift = PW'(pp);
      2'd3:    pp_shift = PW'(pp) << WIDTH;
      default: pp_shift = PW'(pp) << H;
    endcase
    acc_sum = acc_q + pp_shift;
  end

`ifdef VEDIC_SIGNED_EN
  logic neg_q, neg_d;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    result;
  // The most-negative value negates to itself, which is the correct unsigned magnitude.
  assign mag_a  = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign mag_b  = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign result = neg_q ? (~acc_sum + 1'b1) : acc_sum;
`else
  logic [PW-1:0] result;
  assign result = acc_sum;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    c_d     = c_q;
`ifdef VEDIC_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef VEDIC_SIGNED_EN
          ra_d  = mag_a;
          rb_d  = mag_b;
          neg_d = a[WIDTH-1] ^ b[WIDTH-1];
`else
          ra_d  = a;
          rb_d  = b;
`endif
          acc_d   = '0;
          step_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d  = acc_sum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          c_d     = result;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      c_q     <= '0;
`ifdef VEDIC_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
`ifdef VEDIC_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign c         = c_q;

endmodule

// File: tb/tb_vedic_mult_iter.sv
// Self-checking bench for vedic_mult_iter at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_vedic_mult_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;
  logic        iv16, ir16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] c16;

  int n_checks = 0;
  int n_fail   = 0;

  vedic_mult_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .c(c8), .busy(busy8)
  );

  vedic_mult_iter #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .c(c16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y);
    longint p;
`ifdef VEDIC_SIGNED_EN
    p = longint'($signed(x)) * longint'($signed(y));
`else
    p = longint'(x) * longint'(y);
`endif
    return p[15:0];
  endfunction

  function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y);
    longint p;
`ifdef VEDIC_SIGNED_EN
    p = longint'($signed(x)) * longint'($signed(y));
`else
    p = longint'(x) * longint'(y);
`endif
    return p[31:0];
  endfunction

  task automatic wait_ready8();
    int w = 0;
    while (!ir8 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready8_before_accept", ir8, 1);
  endtask

  // One 8-bit transaction; junk keeps in_valid high with other operands while busy.
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input int hold,
                      input bit junk, input logic [7:0] jx, input logic [7:0] jy);
    logic [15:0] e;
    e = model8(x, y);
    wait_ready8();
    iv8 = 1'b1; a8 = x; b8 = y; or8 = (hold == 0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (junk) begin a8 = jx; b8 = jy; end
      else begin iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); end
      check("busy8_compute", busy8, 1);
      check("in_ready8_compute", ir8, 0);
      check("out_valid8_early", ov8, 0);
      @(negedge clk);
    end
    iv8 = 1'b0;
    check("out_valid8_latency", ov8, 1);
    check("c8_result", c8, e);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("out_valid8_hold", ov8, 1);
      check("c8_stable", c8, e);
    end
    or8 = 1'b1;
    @(negedge clk);
    check("out_valid8_drop", ov8, 0);
    check("in_ready8_return", ir8, 1);
    check("busy8_idle", busy8, 0);
    or8 = 1'b0;
  endtask

  task automatic run16(input logic [15:0] x, input logic [15:0] y);
    int cnt = 0;
    int w = 0;
    while (!ir16 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready16_before_accept", ir16, 1);
    iv16 = 1'b1; a16 = x; b16 = y; or16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    while (!ov16 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("latency16", cnt, 4);
    check("c16_result", c16, model16(x, y));
    @(negedge clk);
    check("out_valid16_drop", ov16, 0);
  endtask

  initial begin
    rst = 1'b1;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready8", ir8, 1);
    check("rst_out_valid8", ov8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_c8", c8, 0);
    check("rst_c16", c16, 0);
    check("rst_in_ready16", ir16, 1);
    rst = 1'b0;

    run8(8'd255, 8'd255, 0, 1'b0, 8'd0, 8'd0);
    run8(8'd136, 8'd128, 3, 1'b0, 8'd0, 8'd0);
    run8(8'd4, 8'd2, 0, 1'b1, 8'd6, 8'd8);
    run8(8'd6, 8'd8, 0, 1'b0, 8'd0, 8'd0);

    // Abort a computation with reset at step 2.
    wait_ready8();
    iv8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", ov8, 0);
    check("abort_c", c8, 0);
    check("abort_in_ready", ir8, 1);
    check("abort_busy", busy8, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_no_output", ov8, 0);
    end
    run8(8'd0, 8'd0, 0, 1'b0, 8'd0, 8'd0);

    run8(8'h80, 8'h80, 1, 1'b0, 8'd0, 8'd0);
    run8(8'h80, 8'h7F, 0, 1'b0, 8'd0, 8'd0);
    run8(8'hFD, 8'h05, 0, 1'b0, 8'd0, 8'd0);

    for (int n = 0; n < 24; n++) begin
      run8(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
           1'($urandom), 8'($urandom), 8'($urandom));
    end

    run16(16'hFFFF, 16'hFFFF);
    run16(16'h1234, 16'h0010);
    run16(16'h8000, 16'h8000);
    for (int n = 0; n < 10; n++) begin
      run16(16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
